// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frame sequencer for a 32-point pipelined FFT datapath
//
// Purpose: accepts samples, numbers them within a 32-sample frame, produces the
// datapath advance strobe, tracks {valid,last} tags through the pipeline latency,
// drives the per-stage twiddle ROM addresses and flags output samples.
//
// Optional feature: define FFT_SEQ_FRAME_CNT_EN to build the completed-frame
// counter; otherwise frame_cnt is tied to 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready upstream sample handshake
//   abort             discard the partially accepted frame
//   pipe_en           datapath advance strobe
//   samp_idx          index of the sample accepted this cycle
//   rom16/8/4/2_addr  twiddle addresses for stages 1..4
//   out_valid/last    FFT output sample valid / final sample of a frame
//   busy              sequencer not idle
//   frame_cnt         completed-frame count
module fft_frame_sequencer #(
  parameter int PIPE_LAT  = 46,
  parameter int FRAME_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        abort,
  output logic        pipe_en,
  output logic [4:0]  samp_idx,
  output logic [3:0]  rom16_addr,
  output logic [2:0]  rom8_addr,
  output logic [1:0]  rom4_addr,
  output logic        rom2_addr,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [4:0]          samp_idx_q, samp_idx_d;
  logic [4:0]          pos_q, pos_d;
  logic [6:0]          inflight_q, inflight_d;
  logic [PIPE_LAT-1:0] tag_v_q, tag_v_d;
  logic [PIPE_LAT-1:0] tag_l_q, tag_l_d;
  logic                accept;
  logic [4:0]          pos_m16, pos_m24, pos_m28, pos_m30;

  always_comb begin
    in_ready  = rst | ~abort;
    accept    = in_valid & in_ready & ~rst;
    pipe_en   = ~rst & (accept | (state_q == DRAIN));
    out_valid = pipe_en & tag_v_q[PIPE_LAT-1];
    out_last  = out_valid & tag_l_q[PIPE_LAT-1];
    busy      = (state_q != IDLE);

    state_d    = state_q;
    samp_idx_d = samp_idx_q;
    pos_d      = pos_q;
    tag_v_d    = tag_v_q;
    tag_l_d    = tag_l_q;
    inflight_d = inflight_q;

    // Simultaneous accept and output leave the count unchanged.
    if (accept && !out_valid) begin
      inflight_d = inflight_q + 7'd1;
    end else if (!accept && out_valid && inflight_q != 7'd0) begin
      inflight_d = inflight_q - 7'd1;
    end

    if (pipe_en) begin
      tag_v_d = {tag_v_q[PIPE_LAT-2:0], accept};
      tag_l_d = {tag_l_q[PIPE_LAT-2:0], accept && (samp_idx_q == LAST_IDX)};
      pos_d   = pos_q + 5'd1;
    end

    // 5-bit index wraps 31 -> 0 on its own.
    if (accept) begin
      samp_idx_d = samp_idx_q + 5'd1;
    end

    if (abort) begin
      // Tags already in the pipe keep flowing; only the frame position restarts.
      samp_idx_d = 5'd0;
      state_d    = (inflight_d == 7'd0) ? IDLE : DRAIN;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = RUN;
            pos_d   = 5'd0;
          end
        end
        RUN: begin
          // Index back at 0 with no sample means the frame just ended.
          if (!in_valid && samp_idx_q == 5'd0) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (accept) begin
            state_d = RUN;
          end else if (inflight_d == 7'd0) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      samp_idx_q <= 5'd0;
      pos_q      <= 5'd0;
      inflight_q <= 7'd0;
      tag_v_q    <= '0;
      tag_l_q    <= '0;
    end else begin
      state_q    <= state_d;
      samp_idx_q <= samp_idx_d;
      pos_q      <= pos_d;
      inflight_q <= inflight_d;
      tag_v_q    <= tag_v_d;
      tag_l_q    <= tag_l_d;
    end
  end

  always_comb begin
    pos_m16    = pos_q - 5'd16;
    pos_m24    = pos_q - 5'd24;
    pos_m28    = pos_q - 5'd28;
    pos_m30    = pos_q - 5'd30;
    samp_idx   = samp_idx_q;
    rom16_addr = pos_m16[3:0];
    rom8_addr  = pos_m24[2:0];
    rom4_addr  = pos_m28[1:0];
    rom2_addr  = pos_m30[0];
  end

`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (out_last && frame_cnt_q != 16'hFFFF) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 The block SHALL have parameter PIPE_LAT, default 46, meaning pipe_en cycles from a sample's acceptance to its appearance at the FFT output.
REQ-002 The block SHALL have parameter FRAME_LEN, default 32, meaning samples per frame; the value is fixed at 32.
REQ-003 The block SHALL have one clock and one reset: asynchronous, active-high.
REQ-004 The block SHALL have these ports, one per line (name  direction  width  meaning):
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  upstream sample present
- in_ready  output  1  sequencer accepts a sample this cycle
- abort  input  1  synchronous discard of the partially accepted frame
- pipe_en  output  1  datapath advance strobe
- samp_idx  output  5  index within the frame of the sample accepted this cycle
- rom16_addr  output  4  stage-1 twiddle address
- rom8_addr  output  3  stage-2 twiddle address
- rom4_addr  output  2  stage-3 twiddle address
- rom2_addr  output  1  stage-4 twiddle address
- out_valid  output  1  FFT output sample valid this cycle
- out_last  output  1  final output sample of a frame
- busy  output  1  state is not IDLE
- frame_cnt  output  16  completed-frame count (see Configuration)

Function
REQ-005 The block SHALL implement states IDLE, RUN and DRAIN.
REQ-006 A sample SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 in IDLE, RUN and DRAIN, and 0 in the cycle abort is 1.
REQ-007 IDLE SHALL go to RUN on acceptance; samp_idx SHALL be 0 for that sample.
REQ-008 In RUN, samp_idx SHALL increment by 1 per accepted sample and wrap 31->0.
REQ-009 In RUN, in_valid low mid-frame SHALL hold all counters, with pipe_en 0.
REQ-010 Acceptance at samp_idx 31 with in_valid low in the next cycle SHALL move the block to DRAIN; a sample accepted at idx 31 followed by in_valid high SHALL keep the block in RUN (back-to-back frames).
REQ-011 pipe_en SHALL be 1 on acceptance, 1 in every DRAIN cycle, and 0 otherwise.
REQ-012 In DRAIN, in_valid high SHALL be accepted as samp_idx 0 of the next frame and move the block to RUN.
REQ-013 DRAIN SHALL go to IDLE when the in-flight count reaches 0.
REQ-014 The block SHALL keep a PIPE_LAT-deep tag shift register of {valid,last}, advanced only on pipe_en; an accepted sample enters as {1, samp_idx==31}, and a bubble enters as {0,0}.
REQ-015 out_valid SHALL be pipe_en AND the tail valid bit; out_last SHALL be out_valid AND the tail last bit.
REQ-016 The block SHALL keep a position counter pos[4:0], incremented on each pipe_en and cleared to 0 on an acceptance from IDLE.
REQ-017 The ROM addresses SHALL be: rom16_addr = (pos-16)[3:0], rom8_addr = (pos-24)[2:0], rom4_addr = (pos-28)[1:0], rom2_addr = (pos-30)[0], all modulo-32 arithmetic.
REQ-018 The in-flight counter SHALL be 7 bits: +1 on acceptance and -1 on out_valid, so that simultaneous events give a net change of 0; it SHALL never underflow.
REQ-019 abort SHALL clear samp_idx and enter IDLE if in-flight is 0, or DRAIN otherwise.
REQ-020 On abort, tags already in the shift register SHALL still emerge, and the aborted partial frame SHALL produce no out_last.
REQ-021 busy SHALL be 1 in RUN and DRAIN.

Reset
REQ-022 rst SHALL immediately force: state IDLE; samp_idx, pos, in-flight, all tags, out_valid, out_last, pipe_en = 0; in_ready = 1; frame_cnt = 0.
REQ-023 Reset asserted mid-frame SHALL drop all in-flight samples, and no out_valid SHALL occur after release until new samples are accepted.

Configuration
REQ-024 With macro FFT_SEQ_FRAME_CNT_EN defined, frame_cnt SHALL increment on each out_last and saturate at 65535.
REQ-025 Without FFT_SEQ_FRAME_CNT_EN, frame_cnt SHALL be constant 0 and the counter SHALL NOT be built.

Verification
REQ-026 32 consecutive valid samples after reset -> samp_idx 0..31, DRAIN entered, first out_valid 46 pipe_en cycles after the first acceptance, out_last on the 32nd output, then IDLE.
REQ-027 64 back-to-back samples -> no DRAIN between frames, exactly two out_last pulses, frame_cnt=2 with the macro and 0 without.
REQ-028 in_valid low for 5 cycles at samp_idx 10 -> pipe_en 0 and rom16_addr/samp_idx frozen for those 5 cycles, then resuming at idx 11.
REQ-029 abort at samp_idx 12 -> no out_last, exactly 12 out_valid pulses, then IDLE.
REQ-030 rst pulse during DRAIN -> all outputs 0 (in_ready 1) asynchronously, and no out_valid afterwards.
REQ-031 New frame arriving 3 cycles into DRAIN -> samp_idx 0, state RUN, and the previous frame's outputs continue uninterrupted.
